i2c_txn_queue: RTL and testbench

- Transaction buffer directly upstream of i2c_drv.
- Accepts (word_addr, wdata) write requests from a producer (OLED init/refresh sequencer) through a valid/ready handshake and stores them in a FIFO.
- Issues them one at a time to i2c_drv using its exec-pulse / done-pulse protocol.
- Decouples producer pacing from I2C bus latency and enforces a minimum inter-transaction gap.

---
 rtl/i2c_pkg.sv | 13 +
 rtl/sync_fifo.sv | 41 ++++
 rtl/i2c_txn_queue.sv | 115 +++++++++++
 tb/tb_i2c_txn_queue.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM encodings, default widths and transaction type for i2c_txn_queue.
package i2c_pkg;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } txn_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: register FIFO with wrap-bit pointers; flush drops all entries and any same-cycle push.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    logic [PW:0] wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic do_push, do_pop;
    assign level = wr_q - rd_q;
    assign empty = wr_q == rd_q;
    assign full = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign do_push = push && !full && !flush;
    assign do_pop = pop && !empty && !flush;
    assign wr_d = wr_q + (PW+1)'(do_push);
    assign rd_d = flush ? wr_q : rd_q + (PW+1)'(do_pop);
    assign dout = mem_q[rd_q[PW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[PW-1:0]] <= din;
    end
endmodule

// File: rtl/i2c_txn_queue.sv
// i2c_txn_queue: buffers write requests and issues them to i2c_drv with an exec/done handshake and inter-transaction gap.
// Define I2C_TXN_TIMEOUT_EN to build a WAIT-state watchdog that drops stalled transactions and sets tmo_err.
module i2c_txn_queue
    import i2c_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int GAP_CYCLES = 4
`ifdef I2C_TXN_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       flush,
    output logic                       exec,
    output logic [ADDR_W-1:0]          word_addr,
    output logic [DATA_W-1:0]          wdata,
    input  logic                       done,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       tmo_err
);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [1:0] ST_AFTER = GAP_CYCLES > 0 ? ST_GAP : ST_IDLE;
    logic [1:0] state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [ADDR_W+DATA_W-1:0] head;
    logic full, empty, pop, tmo_hit;
    sync_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_valid),
        .pop   (pop),
        .flush (flush),
        .din   ({push_addr, push_data}),
        .dout  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );
    assign push_ready = !full;
    assign pop = state_q == ST_IDLE && !empty && !flush;
    assign exec = state_q == ST_ISSUE;
    assign busy = state_q != ST_IDLE;
    assign word_addr = addr_q;
    assign wdata = data_q;
`ifdef I2C_TXN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic tmo_err_q, tmo_err_d;
    // Counter holds the number of completed WAIT cycles, so the hit fires on the TIMEOUT_CYCLES-th one.
    assign tmo_hit = state_q == ST_WAIT && !done && tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1);
    assign tmo_cnt_d = state_q == ST_WAIT ? tmo_cnt_q + TW'(1) : '0;
    assign tmo_err_d = tmo_hit || (tmo_err_q && !flush);
    assign tmo_err = tmo_err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign tmo_err = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        data_d = data_q;
        gap_d = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    {addr_d, data_d} = head;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (done || tmo_hit) begin
                    state_d = ST_AFTER;
                    gap_d = '0;
                end
            end
            default: begin
                gap_d = gap_q + GW'(1);
                state_d = gap_q == GW'(GAP_CYCLES - 1) ? ST_IDLE : ST_GAP;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q <= '0;
            data_q <= '0;
            gap_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            data_q <= data_d;
            gap_q <= gap_d;
        end
    end
endmodule

// File: tb/tb_i2c_txn_queue.sv
// tb_i2c_txn_queue: directed checks of latency, gap, full/backpressure, flush and reset for i2c_txn_queue.
module tb_i2c_txn_queue;
    logic clk = 1'b0;
    logic rst, push_valid, push_ready, flush, exec, done, busy, tmo_err;
    logic [15:0] push_addr, word_addr;
    logic [7:0] push_data, wdata;
    logic [4:0] level;
    int compared = 0;
    int mismatched = 0;
    int n, k, cnt;

    always #5 clk = ~clk;

    i2c_txn_queue dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_addr  (push_addr),
        .push_data  (push_data),
        .flush      (flush),
        .exec       (exec),
        .word_addr  (word_addr),
        .wdata      (wdata),
        .done       (done),
        .busy       (busy),
        .level      (level),
        .tmo_err    (tmo_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_exec(output int cycles);
        cycles = 0;
        while (exec !== 1'b1 && cycles < 30) begin
            step;
            cycles++;
        end
    endtask

    task automatic issue_next(input logic [15:0] a, input logic [7:0] d, input logic [4:0] lv, input string tag);
        int c;
        step;
        done = 1'b1;
        step;
        done = 1'b0;
        wait_exec(c);
        chk({tag, " gap"}, c, 5);
        chk({tag, " addr"}, word_addr, a);
        chk({tag, " data"}, wdata, d);
        chk({tag, " level"}, level, lv);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        push_valid = 1'b0;
        push_addr = '0;
        push_data = '0;
        flush = 1'b0;
        done = 1'b0;
        repeat (3) step;
        rst = 1'b0;
        step;
        chk("rst push_ready", push_ready, 1);
        chk("rst exec", exec, 0);
        chk("rst word_addr", word_addr, 0);
        chk("rst wdata", wdata, 0);
        chk("rst busy", busy, 0);
        chk("rst level", level, 0);
        chk("rst tmo_err", tmo_err, 0);

        push_addr = 16'h0000;
        push_data = 8'hAE;
        push_valid = 1'b1;
        step;
        push_valid = 1'b0;
        chk("lat level", level, 1);
        chk("lat exec early", exec, 0);
        step;
        chk("lat exec", exec, 1);
        chk("lat addr", word_addr, 16'h0000);
        chk("lat data", wdata, 8'hAE);
        chk("lat level pop", level, 0);
        chk("lat busy", busy, 1);
        step;
        chk("exec one cycle", exec, 0);
        push_addr = 16'h1234;
        push_data = 8'h55;
        push_valid = 1'b1;
        step;
        push_valid = 1'b0;
        chk("wait level", level, 1);
        repeat (3) step;
        chk("wait busy", busy, 1);
        chk("wait addr hold", word_addr, 16'h0000);
        chk("wait no pop", level, 1);
        issue_next(16'h1234, 8'h55, 0, "second");
        done = 1'b1;
        step;
        done = 1'b0;
        repeat (4) step;
        chk("done in ISSUE ignored", busy, 1);
        done = 1'b1;
        step;
        done = 1'b0;
        n = 0;
        while (busy && n < 30) begin
            step;
            n++;
        end
        chk("gap to idle", n, 4);
        chk("idle addr hold", word_addr, 16'h1234);

        k = 0;
        push_valid = 1'b1;
        while (push_ready && k < 40) begin
            push_addr = 16'h0100 + 16'(k);
            push_data = 8'(k);
            step;
            k++;
        end
        chk("fill accepted", k, 17);
        push_addr = 16'h0200;
        push_data = 8'h11;
        repeat (2) step;
        chk("full level", level, 16);
        chk("full ready", push_ready, 0);
        chk("full inflight addr", word_addr, 16'h0100);
        chk("full inflight data", wdata, 8'h00);
        step;
        done = 1'b1;
        step;
        done = 1'b0;
        repeat (4) step;
        chk("full idle busy", busy, 0);
        chk("full idle level", level, 16);
        chk("full idle ready", push_ready, 0);
        step;
        chk("pop exec", exec, 1);
        chk("pop addr", word_addr, 16'h0101);
        chk("pop data", wdata, 8'h01);
        chk("pop no push level", level, 15);
        chk("pop ready", push_ready, 1);
        step;
        push_valid = 1'b0;
        chk("push after pop", level, 16);
        for (int i = 2; i <= 16; i++)
            issue_next(16'h0100 + 16'(i), 8'(i), 5'(17 - i), $sformatf("order%0d", i));
        issue_next(16'h0200, 8'h11, 0, "late push");
        step;
        done = 1'b1;
        step;
        done = 1'b0;
        repeat (6) step;
        chk("drain busy", busy, 0);
        chk("drain level", level, 0);

        push_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_addr = 16'h0300 + 16'(i);
            push_data = 8'h30 + 8'(i);
            step;
        end
        chk("pre-flush level", level, 5);
        chk("pre-flush busy", busy, 1);
        chk("pre-flush addr", word_addr, 16'h0300);
        flush = 1'b1;
        push_addr = 16'h03FF;
        step;
        flush = 1'b0;
        push_valid = 1'b0;
        chk("flush level", level, 0);
        chk("flush keeps txn", busy, 1);
        done = 1'b1;
        step;
        done = 1'b0;
        cnt = 0;
        repeat (15) begin
            step;
            if (exec) cnt++;
        end
        chk("flush no exec", cnt, 0);
        chk("flush idle", busy, 0);
        chk("flush level end", level, 0);

        push_addr = 16'h4444;
        push_data = 8'h44;
        push_valid = 1'b1;
        step;
        push_valid = 1'b0;
        repeat (2) step;
        chk("pre-rst busy", busy, 1);
        chk("pre-rst addr", word_addr, 16'h4444);
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("mid rst busy", busy, 0);
        chk("mid rst level", level, 0);
        chk("mid rst addr", word_addr, 0);
        chk("mid rst exec", exec, 0);
        repeat (3) step;
        done = 1'b1;
        step;
        done = 1'b0;
        cnt = 0;
        repeat (10) begin
            step;
            if (exec) cnt++;
        end
        chk("stale done exec", cnt, 0);
        chk("stale done busy", busy, 0);
        chk("stale done level", level, 0);
        chk("tmo_err tied", tmo_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
